// File: rtl/m16_deframer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : m16_deframer_if                                               |
// | Purpose  : Bundles the serial input and the recovered-word outputs of    |
// |            the M16 deframer.                                             |
// | Signals  : iBitEn      - bit strobe, iSerial valid on this cycle         |
// |            iSerial     - NRZ serial data, MSB of each word first         |
// |            oWord       - recovered 12-bit word                           |
// |            oWordValid  - one-cycle pulse, oWord/oAddr/oNumGrp valid      |
// |            oAddr       - word index inside the frame                     |
// |            oNumGrp     - group number of oAddr                           |
// |            oFrameStart - pulses with oWordValid when oAddr == 0          |
// |            oLocked     - high while frame sync is held                   |
// |            oErrCnt     - marker-miss counter                             |
// | Modports : slave  - the deframer (consumes bits, produces words)         |
// |            master - the environment (drives bits, observes words)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface m16_deframer_if;
  logic        iBitEn;
  logic        iSerial;
  logic [11:0] oWord;
  logic        oWordValid;
  logic [10:0] oAddr;
  logic [4:0]  oNumGrp;
  logic        oFrameStart;
  logic        oLocked;
  logic [15:0] oErrCnt;

  modport slave (
    input  iBitEn,
    input  iSerial,
    output oWord,
    output oWordValid,
    output oAddr,
    output oNumGrp,
    output oFrameStart,
    output oLocked,
    output oErrCnt
  );

  modport master (
    output iBitEn,
    output iSerial,
    input  oWord,
    input  oWordValid,
    input  oAddr,
    input  oNumGrp,
    input  oFrameStart,
    input  oLocked,
    input  oErrCnt
  );
endinterface
`default_nettype wire

// File: rtl/m16_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : m16_deframer                                                  |
// | Purpose  : Receive stage for the M16 serial Orbita stream. Shifts in one |
// |            bit per strobe, hunts for the 12-bit marker word, verifies it |
// |            over consecutive frames, then delivers each recovered word    |
// |            with its in-frame address and group number while locked.     |
// | Ports    : clk   - system clock, rising edge                             |
// |            reset - synchronous, active-low                               |
// |            bus   - m16_deframer_if.slave (serial in, recovered words out)|
// | Options  : M16_DEFRAMER_ERRCNT_EN - when defined, oErrCnt counts marker  |
// |            mismatches seen in VERIFY and LOCKED (saturating, cleared     |
// |            only by reset); otherwise oErrCnt is tied to zero.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module m16_deframer #(
  parameter logic [11:0] SYNC_WORD   = 12'hE26,
  parameter int          FRAME_WORDS = 2048,
  parameter int          GRP_WORDS   = 64,
  parameter int          LOCK_CNT    = 2,
  parameter int          LOSS_CNT    = 2
) (
  input  wire logic     clk,
  input  wire logic     reset,
  m16_deframer_if.slave bus
);

  localparam int         ADDR_W    = $clog2(FRAME_WORDS);
  localparam int         GRP_SHIFT = $clog2(GRP_WORDS);
  localparam logic [7:0] c_lockCnt = 8'(LOCK_CNT);
  localparam logic [7:0] c_lossCnt = 8'(LOSS_CNT);
  localparam logic [3:0] c_lastBit = 4'd11;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Only 11 bits are kept: the 12th bit of any candidate word is the bit
  // arriving on the current strobe.
  logic [10:0]       r_sh;
  logic [3:0]        r_bitCnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_good;
  logic [7:0]        r_miss;

  logic [11:0] r_word;
  logic        r_wordValid;
  logic [10:0] r_addrOut;
  logic [4:0]  r_grpOut;
  logic        r_frameStart;
  logic        r_locked;

  logic [11:0] w_shNext;
  logic        w_wordDone;
  logic        w_markerSlot;
  logic        w_markerOk;
  logic        w_markerBad;
  logic        w_huntHit;
  logic        w_emit;

  assign w_shNext     = {r_sh, bus.iSerial};
  assign w_huntHit    = bus.iBitEn && (r_state == HUNT) && (w_shNext == SYNC_WORD);
  assign w_wordDone   = bus.iBitEn && (r_state != HUNT) && (r_bitCnt == c_lastBit);
  assign w_markerSlot = w_wordDone && (r_addr == '0);
  assign w_markerOk   = w_markerSlot && (w_shNext == SYNC_WORD);
  assign w_markerBad  = w_markerSlot && (w_shNext != SYNC_WORD);

  // Words are delivered while locked, including the marker that completes
  // lock and the marker that causes loss of lock.
  assign w_emit = w_wordDone && ((r_state == LOCKED) || (w_nextState == LOCKED));

  // ---------------------------------------------------------------- FSM --
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      HUNT: begin
        if (w_huntHit) begin
          w_nextState = VERIFY;
        end
      end
      VERIFY: begin
        if (w_markerOk && ((r_good + 8'd1) >= c_lockCnt)) begin
          w_nextState = LOCKED;
        end else if (w_markerBad) begin
          w_nextState = HUNT;
        end
      end
      LOCKED: begin
        if (w_markerBad && ((r_miss + 8'd1) >= c_lossCnt)) begin
          w_nextState = HUNT;
        end
      end
      default: begin
        w_nextState = HUNT;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath --
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sh         <= '0;
      r_bitCnt     <= '0;
      r_addr       <= '0;
      r_good       <= '0;
      r_miss       <= '0;
      r_word       <= '0;
      r_wordValid  <= 1'b0;
      r_addrOut    <= '0;
      r_grpOut     <= '0;
      r_frameStart <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_wordValid  <= 1'b0;
      r_frameStart <= 1'b0;
      r_locked     <= (w_nextState == LOCKED);

      if (bus.iBitEn) begin
        r_sh <= w_shNext[10:0];

        if (r_state == HUNT) begin
          // The marker just found is word 0, so the next word is word 1.
          if (w_huntHit) begin
            r_bitCnt <= 4'd0;
            r_addr   <= ADDR_W'(1);
            r_good   <= 8'd1;
            r_miss   <= 8'd0;
          end
        end else begin
          r_bitCnt <= (r_bitCnt == c_lastBit) ? 4'd0 : (r_bitCnt + 4'd1);

          // Frame length is a power of two, so the counter wraps by itself.
          if (w_wordDone) begin
            r_addr <= r_addr + ADDR_W'(1);
          end

          if (w_markerOk) begin
            r_miss <= 8'd0;
            if (r_state == VERIFY) begin
              r_good <= r_good + 8'd1;
            end
          end

          if (w_markerBad && (r_state == LOCKED)) begin
            r_miss <= r_miss + 8'd1;
          end
        end

        if (w_emit) begin
          r_word       <= w_shNext;
          r_wordValid  <= 1'b1;
          r_addrOut    <= 11'(r_addr);
          r_grpOut     <= 5'(r_addr >> GRP_SHIFT);
          r_frameStart <= (r_addr == '0);
        end
      end
    end
  end

  assign bus.oWord       = r_word;
  assign bus.oWordValid  = r_wordValid;
  assign bus.oAddr       = r_addrOut;
  assign bus.oNumGrp     = r_grpOut;
  assign bus.oFrameStart = r_frameStart;
  assign bus.oLocked     = r_locked;

  // ------------------------------------------------- marker-miss counter --
`ifdef M16_DEFRAMER_ERRCNT_EN
  logic [15:0] r_errCnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_errCnt <= '0;
    end else if (w_markerBad && (r_errCnt != 16'hFFFF)) begin
      r_errCnt <= r_errCnt + 16'd1;
    end
  end

  assign bus.oErrCnt = r_errCnt;
`else
  assign bus.oErrCnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m16_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_m16_deframer                                               |
// | Purpose  : Directed self-checking bench for m16_deframer. Uses a short   |
// |            frame (64 words, 4 words per group) so that several frames    |
// |            fit in a small number of cycles. Frame data: word 0 is the    |
// |            marker, word n carries n.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_m16_deframer;

  localparam int          FW     = 64;
  localparam int          GW     = 4;
  localparam logic [11:0] MARKER = 12'hE26;
  localparam logic [11:0] BAD    = 12'h000;

`ifdef M16_DEFRAMER_ERRCNT_EN
  localparam int ERRCNT_ON = 1;
`else
  localparam int ERRCNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  m16_deframer_if bus ();

  m16_deframer #(
    .SYNC_WORD   (MARKER),
    .FRAME_WORDS (FW),
    .GRP_WORDS   (GW),
    .LOCK_CNT    (2),
    .LOSS_CNT    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nVectors     = 0;
  int nMiscompares = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string pfx);
    checkVal({pfx, ".oWord"},       32'(bus.oWord),       32'd0);
    checkVal({pfx, ".oWordValid"},  32'(bus.oWordValid),  32'd0);
    checkVal({pfx, ".oAddr"},       32'(bus.oAddr),       32'd0);
    checkVal({pfx, ".oNumGrp"},     32'(bus.oNumGrp),     32'd0);
    checkVal({pfx, ".oFrameStart"}, 32'(bus.oFrameStart), 32'd0);
    checkVal({pfx, ".oLocked"},     32'(bus.oLocked),     32'd0);
    checkVal({pfx, ".oErrCnt"},     32'(bus.oErrCnt),     32'd0);
  endtask

  // Hold reset low for 3 clocks while the strobe toggles.
  task automatic applyReset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.iBitEn  = (i % 2 == 0);
      bus.iSerial = 1'b1;
      tick();
    end
    bus.iBitEn  = 1'b0;
    bus.iSerial = 1'b0;
    reset       = 1'b1;
  endtask

  // Send the top nb bits of w back to back, without checks.
  task automatic sendBits(input logic [11:0] w, input int nb);
    for (int i = 11; i > 11 - nb; i--) begin
      bus.iBitEn  = 1'b1;
      bus.iSerial = w[i];
      tick();
    end
    bus.iBitEn = 1'b0;
  endtask

  // Send one word, one strobe every (gap+1) clocks, and check what appears
  // right after the strobe carrying its last bit.
  task automatic sendWord(input logic [11:0] w, input int gap, input bit expEmit, input int expAddr);
    for (int i = 11; i >= 0; i--) begin
      bus.iBitEn  = 1'b1;
      bus.iSerial = w[i];
      tick();
      bus.iBitEn = 1'b0;
      if (i == 1) begin
        checkVal("latency.early", 32'(bus.oWordValid), 32'd0);
      end
      if (i != 0) begin
        repeat (gap) tick();
      end
    end
    checkVal("oWordValid", 32'(bus.oWordValid), 32'(expEmit));
    if (expEmit) begin
      checkVal("oWord",       32'(bus.oWord),       32'(w));
      checkVal("oAddr",       32'(bus.oAddr),       32'(expAddr));
      checkVal("oNumGrp",     32'(bus.oNumGrp),     32'(expAddr / GW));
      checkVal("oFrameStart", 32'(bus.oFrameStart), 32'(expAddr == 0));
    end
    if (gap > 0) begin
      repeat (gap) tick();
      checkVal("pulseWidth", 32'(bus.oWordValid), 32'd0);
      if (expEmit) begin
        checkVal("holdWord", 32'(bus.oWord), 32'(w));
      end
    end
  endtask

  // mode 0: nothing delivered, 1: every word delivered, 2: only the marker.
  task automatic sendFrame(input logic [11:0] marker, input int gap, input int mode, input bit expLock);
    sendWord(marker, gap, (mode != 0), 0);
    checkVal("oLocked.afterMarker", 32'(bus.oLocked), 32'(expLock));
    for (int n = 1; n < FW; n++) begin
      sendWord(12'(n), gap, (mode == 1), n);
    end
  endtask

  // Bits ahead of the first marker; no 12-bit window of this run, nor of its
  // overlap with the marker, equals the marker.
  task automatic preamble();
    sendBits(12'hAC0, 12);
    sendBits(12'h000, 3);
  endtask

  initial begin
    reset       = 1'b0;
    bus.iBitEn  = 1'b0;
    bus.iSerial = 1'b0;
    tick();
    tick();

    // Reset with strobes toggling, then idle cycles change nothing.
    applyReset();
    checkAllZero("rst");
    tick();
    tick();
    checkAllZero("idle");

    // Acquire: marker found in frame 1, lock on frame 2's marker.
    preamble();
    sendFrame(MARKER, 0, 0, 1'b0);
    sendFrame(MARKER, 0, 1, 1'b1);
    sendFrame(MARKER, 0, 1, 1'b1);
    checkVal("lock.held", 32'(bus.oLocked), 32'd1);

    // Two consecutive bad markers: first keeps lock, second drops it.
    sendFrame(BAD, 0, 1, 1'b1);
    sendFrame(BAD, 0, 2, 1'b0);
    checkVal("loss.oErrCnt", 32'(bus.oErrCnt), 32'(2 * ERRCNT_ON));
    // Re-hunting starts over; the counter survives loss of lock.
    sendFrame(MARKER, 0, 0, 1'b0);
    checkVal("loss.oErrCntKept", 32'(bus.oErrCnt), 32'(2 * ERRCNT_ON));

    // Single miss between good markers keeps lock.
    applyReset();
    checkVal("rst2.oErrCnt", 32'(bus.oErrCnt), 32'd0);
    preamble();
    sendFrame(MARKER, 0, 0, 1'b0);
    sendFrame(MARKER, 0, 1, 1'b1);
    sendFrame(BAD,    0, 1, 1'b1);
    sendFrame(MARKER, 0, 1, 1'b1);
    checkVal("miss1.oLocked", 32'(bus.oLocked), 32'd1);
    checkVal("miss1.oErrCnt", 32'(bus.oErrCnt), 32'(ERRCNT_ON));

    // Strobe every 7 clocks while locked.
    sendFrame(MARKER, 6, 1, 1'b1);

    // Reset in the middle of word 40 while locked, then reacquire.
    sendWord(MARKER, 0, 1'b1, 0);
    for (int n = 1; n < 40; n++) begin
      sendWord(12'(n), 0, 1'b1, n);
    end
    sendBits(12'd40, 5);
    applyReset();
    checkAllZero("midRst");
    preamble();
    sendFrame(MARKER, 0, 0, 1'b0);
    sendFrame(MARKER, 0, 1, 1'b1);
    checkVal("relock.oLocked", 32'(bus.oLocked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
